// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and counter sizing for the UART receiver
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

   function automatic int cnt_width(input int half);
      return $clog2(2 * half);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - reset-to-1 double flop synchroniser for the idle-high serial line
module sync_2ff (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with framing error flag
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each bit centre.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 30
) (
   output logic [7:0] rdata,
   output logic       rdata_ready,
   output logic       ferr,
   input  logic       rxd,
   input  logic       clk,
   input  logic       rstn
);

   localparam int CW = cnt_width(CLK_PER_HALF_BIT);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_HALF_BIT - 1);

   uart_rx_state_t state_q;
   logic [CW-1:0]  cnt_q;
   logic [2:0]     bitidx_q;
   logic [7:0]     shreg_q;
   logic [7:0]     rdata_q;
   logic           ferr_q;
   logic           ready_q;
   logic           rxd_s;
   logic           sample_now;
   logic           sample_val;

   sync_2ff u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (rxd),
      .q_o  (rxd_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Decision lands one clock after cnt==0, so the reload is one shorter.
   localparam logic [CW-1:0] BIT_LOAD = CW'(2 * CLK_PER_HALF_BIT - 2);
   logic s1_q;
   logic s2_q;
   logic pend_q;

   always_comb begin
      sample_now = pend_q;
      sample_val = (s1_q & s2_q) | (s1_q & rxd_s) | (s2_q & rxd_s);
   end
`else
   localparam logic [CW-1:0] BIT_LOAD = CW'(2 * CLK_PER_HALF_BIT - 1);

   always_comb begin
      sample_now = (cnt_q == '0);
      sample_val = rxd_s;
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitidx_q <= '0;
         shreg_q  <= '0;
         rdata_q  <= '0;
         ferr_q   <= 1'b0;
         ready_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         pend_q   <= 1'b0;
`endif
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  cnt_q   <= HALF_LOAD;
                  state_q <= START;
               end
            end
            default: begin
`ifdef UART_RX_MAJORITY_EN
               if (cnt_q == CW'(1)) s1_q <= rxd_s;
               if (cnt_q == '0 && !pend_q) begin
                  s2_q   <= rxd_s;
                  pend_q <= 1'b1;
               end
`endif
               if (sample_now) begin
`ifdef UART_RX_MAJORITY_EN
                  pend_q <= 1'b0;
`endif
                  cnt_q <= BIT_LOAD;
                  case (state_q)
                     START: begin
                        if (sample_val) begin
                           state_q <= IDLE;
                        end else begin
                           bitidx_q <= '0;
                           state_q  <= DATA;
                        end
                     end
                     DATA: begin
                        shreg_q[bitidx_q] <= sample_val;
                        if (bitidx_q == 3'd7) state_q <= STOP;
                        else bitidx_q <= bitidx_q + 3'd1;
                     end
                     default: begin
                        // Back to IDLE at mid-stop so an immediate next start edge is seen.
                        rdata_q <= shreg_q;
                        ferr_q  <= ~sample_val;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                     end
                  endcase
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   assign rdata       = rdata_q;
   assign ferr        = ferr_q;
   assign rdata_ready = ready_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core against a frame-level model
module tb_uart_rx_core;

   localparam int HALF = 30;
   localparam int BITC = 2 * HALF;

   logic       clk;
   logic       rstn;
   logic       rxd;
   logic [7:0] rdata;
   logic       rdata_ready;
   logic       ferr;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int last_start = 0;
   int last_pulse = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   uart_rx_core #(.CLK_PER_HALF_BIT(HALF)) dut (
      .rdata       (rdata),
      .rdata_ready (rdata_ready),
      .ferr        (ferr),
      .rxd         (rxd),
      .clk         (clk),
      .rstn        (rstn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rdata_ready) begin
         obs_q.push_back({ferr, rdata});
         last_pulse = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rxd = v;
      repeat (BITC) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Model: a well-formed 8N1 frame yields exactly one report {~stop, byte}.
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_it);
      if (expect_it) exp_q.push_back({~stop, b});
      last_start = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop);
      rxd = 1'b1;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (obs_q.size() < exp_q.size() && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (100) @(negedge clk);
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         logic [8:0] o;
         logic [8:0] e;
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, o[7:0], e[7:0]);
         chk({tag, "_ferr"}, o[8], e[8]);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int lat;
      logic [7:0] b;
      logic       s;
      rstn = 1'b0;
      rxd  = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset_rdata", rdata, 8'h00);
      chk("reset_ready", rdata_ready, 1'b0);
      chk("reset_ferr", ferr, 1'b0);
      rstn = 1'b1;

      idle(1000);
      drain("idle");
      chk("idle_rdata", rdata, 8'h00);
      chk("idle_ferr", ferr, 1'b0);

      send_frame(8'hAA, 1'b1, 1'b1);
      drain("frame_aa");
      lat = last_pulse - last_start;
      chk("latency_aa", (lat >= 570 && lat <= 576), 1);

      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      send_frame(8'h55, 1'b1, 1'b1);
      drain("b2b");

      send_frame(8'h3C, 1'b0, 1'b1);
      idle(2 * BITC);
      drain("bad_stop");
      chk("bad_stop_hold", ferr, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      drain("good_stop");

      rxd = 1'b0;
      repeat (20) @(negedge clk);
      idle(3 * BITC);
      drain("glitch");
      send_frame(8'h5A, 1'b1, 1'b1);
      drain("after_glitch");
      chk("hold_rdata", rdata, 8'h5A);

      fork
         send_frame(8'hC3, 1'b1, 1'b0);
         begin
            repeat (5 * BITC + HALF) @(negedge clk);
            rstn = 1'b0;
            repeat (3) @(negedge clk);
            chk("midreset_rdata", rdata, 8'h00);
            chk("midreset_ferr", ferr, 1'b0);
            chk("midreset_ready", rdata_ready, 1'b0);
         end
      join
      idle(BITC);
      rstn = 1'b1;
      idle(BITC);
      drain("aborted");
      send_frame(8'h81, 1'b1, 1'b1);
      drain("after_reset");

      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom);
         s = ($urandom_range(0, 3) != 0);
         send_frame(b, s, 1'b1);
         if (s) idle($urandom_range(0, 90));
         else idle(BITC + $urandom_range(0, 30));
      end
      drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
